debug_capture_serializer: RTL and testbench

Parametrised successor to the single-channel TM4C123GH6PM debug streamer. It arms on request and captures DEPTH samples from one selected channel of a NUM_CH-wide sample bus into an internal buffer at full rate. It then replays the buffer as a gapless serial frame (ser_clk / ser_valid / ser_data) at a divided bit rate the TIVA board can sample reliably. It sits beside any vocoder datapath stage as a non-intrusive probe.

---
 rtl/debug_capture_serializer.sv | 163 ++++++++++++++++
 tb/tb_debug_capture_serializer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/debug_capture_serializer.sv
// debug_capture_serializer: arms on request, captures DEPTH samples of one channel, replays them as a gapless serial frame.
module debug_capture_serializer #(
    parameter int NUM_CH    = 2,
    parameter int SAMPLE_W  = 16,
    parameter int DEPTH     = 1024,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1,
    parameter int HOLDOFF   = 256,
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       arm,
    input  logic [CW-1:0]              ch_sel,
    input  logic                       sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
    output logic                       busy,
    output logic                       ser_clk,
    output logic                       ser_valid,
    output logic                       ser_data,
    output logic [15:0]                frames_sent
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = SAMPLE_W > 1 ? $clog2(SAMPLE_W) : 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam int HW = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SEND, S_HOLDOFF} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                go_q, go_d;
    logic [DW-1:0]       div_q, div_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [SAMPLE_W-1:0] sh_q, sh_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                busy_q, busy_d, ser_clk_q, ser_clk_d;
    logic                ser_valid_q, ser_valid_d, ser_data_q, ser_data_d;
    logic [15:0]         frames_q, frames_d;
    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [SAMPLE_W-1:0] rd_data_q, sel_sample, v;
    logic                wr_en, load, done;

    assign sel_sample  = sample_in[ch_q*SAMPLE_W +: SAMPLE_W];
    assign busy        = busy_q;
    assign ser_clk     = ser_clk_q;
    assign ser_valid   = ser_valid_q;
    assign ser_data    = ser_data_q;
    assign frames_sent = frames_q;

    // Capture buffer: one write port, registered read of the next sample to serialize
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= sel_sample;
        rd_data_q <= mem[rd_ptr_q];
    end

    // Next-state, pointer, bit-timing and output computation
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        go_d        = go_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        ser_clk_d   = ser_clk_q;
        ser_valid_d = ser_valid_q;
        ser_data_d  = ser_data_q;
        frames_d    = frames_q;
        wr_en       = 1'b0;
        load        = !ser_valid_q || bit_q == BW'(SAMPLE_W - 1);
        v           = load ? rd_data_q : sh_q;
        // rd_ptr wraps to 0 only once the last sample has been loaded
        done        = ser_valid_q && bit_q == BW'(SAMPLE_W - 1) && rd_ptr_q == '0;
        case (state_q)
            S_IDLE: if (arm) begin
                state_d  = S_CAPTURE;
                ch_d     = ({1'b0, ch_sel} >= (CW+1)'(NUM_CH)) ? CW'(NUM_CH - 1) : ch_sel;
                wr_ptr_d = '0;
            end
            S_CAPTURE: if (sample_valid) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (wr_ptr_q == AW'(DEPTH - 1)) begin
                    state_d  = S_SEND;
                    rd_ptr_d = '0;
                    go_d     = 1'b0;
                end
            end
            S_SEND: begin
                if (!go_q) begin
                    go_d = 1'b1;
                end else if (!ser_valid_q || div_q == DW'(CLK_DIV - 1)) begin
                    if (done) begin
                        state_d     = S_HOLDOFF;
                        hold_d      = '0;
                        ser_valid_d = 1'b0;
                        ser_data_d  = 1'b0;
                        ser_clk_d   = 1'b0;
                    end else begin
                        ser_valid_d = 1'b1;
                        ser_clk_d   = 1'b0;
                        div_d       = '0;
                        bit_d       = load ? '0 : bit_q + 1'b1;
                        rd_ptr_d    = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
                        ser_data_d  = MSB_FIRST != 0 ? v[SAMPLE_W-1] : v[0];
                        sh_d        = MSB_FIRST != 0 ? v << 1 : v >> 1;
                    end
                end else begin
                    div_d     = div_q + 1'b1;
                    ser_clk_d = div_d >= DW'(CLK_DIV / 2);
                end
            end
            S_HOLDOFF: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HW'(HOLDOFF - 1)) begin
                    state_d  = S_IDLE;
                    frames_d = frames_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
    end

    // State and output registers; reset aborts any capture or frame immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            go_q        <= 1'b0;
            div_q       <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            hold_q      <= '0;
            busy_q      <= 1'b0;
            ser_clk_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_data_q  <= 1'b0;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            go_q        <= go_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            ser_clk_q   <= ser_clk_d;
            ser_valid_q <= ser_valid_d;
            ser_data_q  <= ser_data_d;
            frames_q    <= frames_d;
        end
    end
endmodule

// File: tb/tb_debug_capture_serializer.sv
// tb_debug_capture_serializer: table-driven frame checks on MSB-first and LSB-first instances sharing one stimulus.
module tb_debug_capture_serializer;
    localparam int NUM_CH = 2, SAMPLE_W = 16, DEPTH = 4, CLK_DIV = 4, HOLDOFF = 8;
    localparam int FRAME = DEPTH * SAMPLE_W * CLK_DIV;

    logic        clk = 1'b0, reset_n = 1'b0, arm = 1'b0, ch_sel = 1'b0, sample_valid = 1'b0;
    logic [31:0] sample_in = '0;
    logic        busy_m, sclk_m, sval_m, sdat_m, busy_l, sclk_l, sval_l, sdat_l;
    logic [15:0] fs_m, fs_l;

    always #5 clk = ~clk;

    debug_capture_serializer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV),
                               .MSB_FIRST(1), .HOLDOFF(HOLDOFF)) u_msb (
        .clk(clk), .reset_n(reset_n), .arm(arm), .ch_sel(ch_sel), .sample_valid(sample_valid),
        .sample_in(sample_in), .busy(busy_m), .ser_clk(sclk_m), .ser_valid(sval_m), .ser_data(sdat_m),
        .frames_sent(fs_m));

    debug_capture_serializer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV),
                               .MSB_FIRST(0), .HOLDOFF(HOLDOFF)) u_lsb (
        .clk(clk), .reset_n(reset_n), .arm(arm), .ch_sel(ch_sel), .sample_valid(sample_valid),
        .sample_in(sample_in), .busy(busy_l), .ser_clk(sclk_l), .ser_valid(sval_l), .ser_data(sdat_l),
        .frames_sent(fs_l));

    // word k of each 64-bit field sits at bits [k*16 +: 16]
    typedef struct packed {
        logic        ch_sel;
        logic [7:0]  gap;
        logic [63:0] ch0;
        logic [63:0] ch1;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs [5];
    int          checks = 0, errors = 0;
    logic [15:0] exp_frames = '0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [63:0] w, input int c, input bit msb);
        int n;
        logic [15:0] word;
        n = c / CLK_DIV;
        word = w[(n / SAMPLE_W) * SAMPLE_W +: SAMPLE_W];
        return msb ? word[SAMPLE_W - 1 - (n % SAMPLE_W)] : word[n % SAMPLE_W];
    endfunction

    task automatic run_frame(input int i, input int abort_bit);
        vec_t v;
        int n;
        logic e_clk;
        v = vecs[i];
        n = 0;
        while (busy_m && n < 400) begin
            tick();
            n++;
        end
        chk("idle_before_arm", {30'd0, busy_m, busy_l}, 32'd0);
        ch_sel = v.ch_sel;
        arm = 1'b1;
        sample_valid = 1'b1;
        sample_in = 32'hDEADBEEF;
        tick();
        arm = 1'b0;
        chk("busy_after_arm", {30'd0, busy_m, busy_l}, 32'd3);
        for (int k = 0; k < DEPTH; k++) begin
            for (int g = 1; g < int'(v.gap); g++) begin
                sample_valid = 1'b0;
                sample_in = $urandom;
                tick();
            end
            sample_valid = 1'b1;
            sample_in = {v.ch1[k*16 +: 16], v.ch0[k*16 +: 16]};
            tick();
        end
        sample_valid = 1'b0;
        for (int p = 0; p < 2; p++) begin
            chk("pre_send", {28'd0, busy_m, sval_m, busy_l, sval_l}, 32'hA);
            tick();
        end
        for (int c = 0; c < FRAME; c++) begin
            e_clk = logic'((c % CLK_DIV) >= CLK_DIV / 2);
            chk($sformatf("frame%0d_c%0d", i, c), {26'd0, sval_m, sclk_m, sdat_m, sval_l, sclk_l, sdat_l},
                {26'd0, 1'b1, e_clk, exp_bit(v.exp, c, 1'b1), 1'b1, e_clk, exp_bit(v.exp, c, 1'b0)});
            if (abort_bit >= 0 && c == abort_bit * CLK_DIV) begin
                reset_n = 1'b0;
                #1;
                chk("abort_outputs", {24'd0, busy_m, sclk_m, sval_m, sdat_m, busy_l, sclk_l, sval_l, sdat_l}, 32'd0);
                chk("abort_frames", {fs_m, fs_l}, 32'd0);
                exp_frames = '0;
                sample_valid = 1'b0;
                return;
            end
            sample_valid = (c % 2) == 1;
            sample_in = $urandom;
            arm = (c == 100);
            tick();
        end
        sample_valid = 1'b0;
        arm = 1'b0;
        for (int h = 0; h < HOLDOFF; h++) begin
            chk("holdoff", {24'd0, busy_m, sclk_m, sval_m, sdat_m, busy_l, sclk_l, sval_l, sdat_l}, 32'h88);
            arm = (h == 3);
            tick();
        end
        exp_frames++;
        chk("busy_fall", {30'd0, busy_m, busy_l}, 32'd0);
        chk("frames_sent", {fs_m, fs_l}, {exp_frames, exp_frames});
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'd1, {16'hFFFF, 16'h8000, 16'h0001, 16'hA5A5}, {16'h4444, 16'h3333, 16'h2222, 16'h1111},
                    {16'hFFFF, 16'h8000, 16'h0001, 16'hA5A5}};
        vecs[1] = '{1'b1, 8'd3, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234},
                    {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}};
        vecs[2] = '{1'b0, 8'd1, {16'h0000, 16'h0000, 16'h8000, 16'h0001}, {16'h7777, 16'h6666, 16'h5555, 16'h4444},
                    {16'h0000, 16'h0000, 16'h8000, 16'h0001}};
        vecs[3] = '{1'b1, 8'd2, {16'h1357, 16'h2468, 16'hACE0, 16'hBDF1}, {16'h8001, 16'h7FFE, 16'h0F0F, 16'hC3C3},
                    {16'h8001, 16'h7FFE, 16'h0F0F, 16'hC3C3}};
        vecs[4] = '{1'b0, 8'd1, {16'h0F0F, 16'h3C3C, 16'hF00D, 16'h5A5A}, {16'h0000, 16'h0000, 16'h0000, 16'h0000},
                    {16'h0F0F, 16'h3C3C, 16'hF00D, 16'h5A5A}};
        repeat (5) @(posedge clk);
        #1;
        chk("reset_outputs", {24'd0, busy_m, sclk_m, sval_m, sdat_m, busy_l, sclk_l, sval_l, sdat_l}, 32'd0);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("idle_after_reset", {24'd0, busy_m, sclk_m, sval_m, sdat_m, busy_l, sclk_l, sval_l, sdat_l}, 32'd0);
        end
        chk("reset_frames", {fs_m, fs_l}, 32'd0);
        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(2, -1);
        run_frame(3, 20);
        repeat (3) tick();
        chk("held_in_reset", {24'd0, busy_m, sclk_m, sval_m, sdat_m, busy_l, sclk_l, sval_l, sdat_l}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_after_abort", {30'd0, busy_m, busy_l}, 32'd0);
        run_frame(4, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
